// File: rtl/reg_bank_sequencer.sv
// Sequences LOAD/CLEAR/INC/DEC commands from two requesters onto a bank of four 16-bit registers.
// Latency grant-to-Ack: 2 cycles LOAD/CLEAR, Cnt+1 cycles INC/DEC, 1 cycle for INC/DEC with Cnt=0.
// Backpressure: requesters hold Req until Ack; round-robin arbitration; inputs sampled only at grant.
module reg_bank_sequencer #(
    parameter int CNT_W = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             ReqA,
    input  logic             ReqB,
    input  logic [1:0]       OpA,
    input  logic [1:0]       OpB,
    input  logic [1:0]       SelA,
    input  logic [1:0]       SelB,
    input  logic [CNT_W-1:0] CntA,
    input  logic [CNT_W-1:0] CntB,
    input  logic [15:0]      DataA,
    input  logic [15:0]      DataB,
    output logic             AckA,
    output logic             AckB,
    output logic             Busy,
    output logic             Owner,
    output logic [3:0]       RegE,
    output logic [1:0]       RegFunSel,
    output logic [15:0]      RegI
);

    // Op encoding shared with the register FunSel input.
    localparam logic [1:0] OP_DEC   = 2'b00;
    localparam logic [1:0] OP_INC   = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic             owner_q, owner_d;
    logic [1:0]       op_q, op_d;
    logic [1:0]       sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      data_q, data_d;
    // Requester that wins the next simultaneous request: 0 = A, 1 = B.
    logic             prio_q, prio_d;

    // Selected requester's fields at the grant edge.
    logic             grant_b;
    logic [1:0]       req_op;
    logic [CNT_W-1:0] req_cnt;

    // State and latched-command registers; reset aborts any command in flight.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            op_q    <= OP_DEC;
            sel_q   <= 2'd0;
            cnt_q   <= '0;
            data_q  <= 16'h0000;
            prio_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            op_q    <= op_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            prio_q  <= prio_d;
        end
    end

    // Arbitration, command latch and next-state sequencing.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        op_d    = op_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        prio_d  = prio_q;
        // B wins when it asks alone, or when both ask and it is B's turn.
        grant_b = ReqB & (~ReqA | prio_q);
        req_op  = grant_b ? OpB : OpA;
        req_cnt = grant_b ? CntB : CntA;

        unique case (state_q)
            IDLE: begin
                if (ReqA || ReqB) begin
                    owner_d = grant_b;
                    op_d    = req_op;
                    sel_d   = grant_b ? SelB : SelA;
                    cnt_d   = req_cnt;
                    data_d  = grant_b ? DataB : DataA;
                    prio_d  = ~grant_b;
                    // A zero-count INC/DEC has nothing to execute.
                    if (!req_op[1] && (req_cnt == '0)) begin
                        state_d = DONE;
                    end else begin
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                if (op_q == OP_LOAD || op_q == OP_CLEAR) begin
                    state_d = DONE;
                end else if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Register-bank drive and handshake outputs decoded from the current state only.
    always_comb begin
        RegE      = 4'b0000;
        RegFunSel = 2'b00;
        RegI      = 16'h0000;
        AckA      = 1'b0;
        AckB      = 1'b0;
        Busy      = (state_q != IDLE);
        Owner     = owner_q;
        if (state_q == EXEC) begin
            RegE      = 4'b0001 << sel_q;
            RegFunSel = op_q;
            if (op_q == OP_LOAD) begin
                RegI = data_q;
            end
        end
        if (state_q == DONE) begin
            AckA = ~owner_q;
            AckB = owner_q;
        end
    end

endmodule

// File: doc/reg_bank_sequencer.md
REG_BANK_SEQUENCER -- requirements
Module: reg_bank_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 4, width of the repeat-count fields CntA/CntB.
REQ-002 SHALL have port Clock  in  1  single clock; all state changes on the rising edge.
REQ-003 SHALL have port Reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports ReqA / ReqB  in  1  requester A / B command request; held high until Ack.
REQ-005 SHALL have ports OpA / OpB  in  2  op: 00 DEC, 01 INC, 10 LOAD, 11 CLEAR (same encoding as register FunSel).
REQ-006 SHALL have ports SelA / SelB  in  2  target register index 0-3.
REQ-007 SHALL have ports CntA / CntB  in  CNT_W  repeat count for INC/DEC; ignored for LOAD/CLEAR.
REQ-008 SHALL have ports DataA / DataB  in  16  load value for LOAD.
REQ-009 SHALL have ports AckA / AckB  out  1  one-cycle completion pulse to the owning requester.
REQ-010 SHALL have port Busy  out  1  high while a command is latched and not yet acknowledged.
REQ-011 SHALL have port Owner  out  1  requester of the latched command: 0 = A, 1 = B.
REQ-012 SHALL have port RegE  out  4  one-hot enable to the four 16-bit registers.
REQ-013 SHALL have port RegFunSel  out  2  function select to all registers.
REQ-014 SHALL have port RegI  out  16  load data to all registers.

Function
REQ-015 SHALL implement the states IDLE, EXEC and DONE.
REQ-016 IDLE: if ReqA or ReqB is high at a rising edge, SHALL grant one requester, latch its Op/Sel/Cnt/Data and Owner, then go to EXEC (or DONE per REQ-021); Busy high from the next cycle.
REQ-017 Arbitration SHALL be round-robin: on a simultaneous request, the requester not granted last wins; after reset A has priority; a lone request is granted immediately.
REQ-018 Inputs SHALL be sampled only at the grant edge; changes to Op/Sel/Cnt/Data/Req during EXEC/DONE have no effect.
REQ-019 EXEC, LOAD/CLEAR: SHALL be exactly one cycle with RegE = one-hot(Sel), RegFunSel = Op, RegI = latched Data (LOAD) or 0 (CLEAR), then DONE.
REQ-020 EXEC, INC/DEC: SHALL be exactly Cnt consecutive cycles with RegE = one-hot(Sel) and RegFunSel = Op, using an internal down-counter, then DONE; register wrap-around (FFFF+1=0, 0-1=FFFF) is the registers' behaviour and is not prevented.
REQ-021 INC/DEC with Cnt = 0 SHALL skip EXEC (go directly from IDLE to DONE) and SHALL never assert RegE.
REQ-022 DONE: SHALL assert exactly one of AckA/AckB (per Owner) for one cycle, keep RegE = 0, then return to IDLE.
REQ-023 Outside EXEC, RegE SHALL be 0000, RegFunSel 00 and RegI 0000.
REQ-024 Total latency, grant edge to Ack cycle, SHALL be 2 cycles for LOAD/CLEAR, Cnt+1 cycles for INC/DEC, and 1 cycle for Cnt = 0.
REQ-025 A Req still high in the IDLE cycle after its own Ack SHALL be treated as a new request, subject to round-robin.
REQ-026 A Req dropped before Ack SHALL NOT abort the operation; Ack is still issued.
REQ-027 Busy SHALL be low in IDLE and high in EXEC and DONE.

Reset
REQ-028 Reset low SHALL immediately force IDLE, with Busy, AckA, AckB, Owner, RegE, RegFunSel, RegI and the count all 0, and round-robin priority set to A.
REQ-029 Reset asserted mid-EXEC SHALL abort the command with no further RegE pulses and no Ack; after release the block waits in IDLE for a fresh request.

Verification
REQ-030 ReqA, OpA=10, SelA=2, DataA=0xBEEF -> next cycle RegE=0100, RegFunSel=10, RegI=0xBEEF for 1 cycle; AckA the cycle after; AckB never.
REQ-031 ReqB, OpB=01, SelB=1, CntB=5 -> RegE=0010 with RegFunSel=01 for exactly 5 cycles, then one AckB pulse; a bench register 1 goes from 0x0003 to 0x0008.
REQ-032 ReqA and ReqB raised together and held for two commands (A: CLEAR reg0; B: DEC reg3, Cnt=2) -> A served first, then B, then A; Owner toggles 0,1,0.
REQ-033 ReqA, OpA=00, CntA=0 -> AckA one cycle after the grant edge; RegE stays 0000 throughout.
REQ-034 Reset pulsed low on the 2nd of 6 INC cycles -> all outputs 0 within the reset, no further RegE, no AckA; after release a simultaneous ReqA/ReqB grants A.
REQ-035 OpA/SelA changed during EXEC of an INC Cnt=3 command -> the latched target and op are unchanged for all 3 cycles.
